// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic bitstream ones-counter.
// popcount_chunk is a plain loop, meant for reference checking, not hardware.
package sc_pkg;

  localparam int DEF_BITSTREAM = 64;
  localparam int DEF_CHUNK     = 8;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  // Number of ones in w[lo +: n].
  function automatic int popcount_chunk(input logic [DEF_BITSTREAM-1:0] w,
                                        input int lo, input int n);
    int c;
    c = 0;
    for (int i = 0; i < DEF_BITSTREAM; i++) begin
      if (i >= lo && i < lo + n && w[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/sc_bitstream_counter_chunk_popcount.sv
// Combinational ones-count of a CHUNK-bit slice, built as a balanced adder tree
// by recursive halving; CHUNK must be a power of two.
module sc_chunk_popcount #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]               bits,
  output logic [$clog2(CHUNK+1)-1:0]     count
);

  if (CHUNK == 1) begin : g_leaf
    assign count = bits;
  end else begin : g_split
    localparam int H  = CHUNK / 2;
    localparam int HW = $clog2(H + 1);

    logic [HW-1:0] lo_cnt;
    logic [HW-1:0] hi_cnt;

    sc_chunk_popcount #(.CHUNK(H)) u_lo (
      .bits  (bits[H-1:0]),
      .count (lo_cnt)
    );

    sc_chunk_popcount #(.CHUNK(H)) u_hi (
      .bits  (bits[CHUNK-1:H]),
      .count (hi_cnt)
    );

    // Doubling a power-of-two chunk adds exactly one bit of count width.
    assign count = {1'b0, lo_cnt} + {1'b0, hi_cnt};
  end

endmodule

// File: rtl/sc_bitstream_counter.sv
// Serial ones-counter for a rotated stochastic bitstream word: CHUNK bits per
// clock, returning the unipolar count and the bipolar value 2*count - BITSTREAM.
module sc_bitstream_counter
  import sc_pkg::*;
#(
  parameter int BITSTREAM = DEF_BITSTREAM,
  parameter int CHUNK     = DEF_CHUNK
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [BITSTREAM-1:0]                 in_bits,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(BITSTREAM+1)-1:0]       out_count,
  output logic signed [$clog2(BITSTREAM+1):0]  out_bipolar
);

  localparam int N  = BITSTREAM / CHUNK;
  localparam int CW = $clog2(BITSTREAM + 1);
  localparam int PW = $clog2(CHUNK + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IW-1:0] LAST    = IW'(N - 1);
  localparam logic [CW:0]   BS_W    = (CW + 1)'(BITSTREAM);
  localparam logic [CW:0]   BIP_RST = ~BS_W + 1'b1;

  if (CHUNK < 1 || CHUNK > BITSTREAM || (CHUNK & (CHUNK - 1)) != 0 ||
      (BITSTREAM % CHUNK) != 0) begin : g_bad_params
    $fatal(1, "sc_bitstream_counter: illegal BITSTREAM=%0d / CHUNK=%0d",
           BITSTREAM, CHUNK);
  end

  state_t                state_q, state_d;
  logic [BITSTREAM-1:0]  sreg_q, sreg_d;
  logic [CW-1:0]         acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [CW-1:0]         out_count_q, out_count_d;
  logic signed [CW:0]    out_bipolar_q, out_bipolar_d;

  logic [PW-1:0]         chunk_cnt;
  logic [CW-1:0]         acc_sum;
  logic [BITSTREAM-1:0]  sreg_shift;

  sc_chunk_popcount #(.CHUNK(CHUNK)) u_chunk_pc (
    .bits  (sreg_q[CHUNK-1:0]),
    .count (chunk_cnt)
  );

  assign acc_sum = acc_q + CW'(chunk_cnt);

  // With a single pass the whole word is consumed at once, so nothing remains.
  if (N > 1) begin : g_shift
    assign sreg_shift = {{CHUNK{1'b0}}, sreg_q[BITSTREAM-1:CHUNK]};
  end else begin : g_noshift
    assign sreg_shift = '0;
  end

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_count_d   = out_count_q;
    out_bipolar_d = out_bipolar_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d     = in_bits;
          acc_d      = '0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = COUNT;
        end
      end
      COUNT: begin
        acc_d  = acc_sum;
        sreg_d = sreg_shift;
        idx_d  = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d         = '0;
          out_valid_d   = 1'b1;
          out_count_d   = acc_sum;
          out_bipolar_d = $signed({acc_sum, 1'b0} - BS_W);
          state_d       = DONE;
        end
      end
      DONE: begin
        // Results stay frozen until the consumer takes them.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sreg_q        <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_count_q   <= '0;
      out_bipolar_q <= $signed(BIP_RST);
    end else begin
      state_q       <= state_d;
      sreg_q        <= sreg_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_count_q   <= out_count_d;
      out_bipolar_q <= out_bipolar_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_count   = out_count_q;
  assign out_bipolar = out_bipolar_q;

endmodule

// File: tb/tb_sc_bitstream_counter.sv
// Bench for sc_bitstream_counter: four instances (CHUNK 8/1/4/64) checked
// against a popcount reference with random words and random backpressure.
module tb_sc_bitstream_counter;
  import sc_pkg::*;

  localparam int NU = 4;

  logic              clk;
  logic              rst;
  logic              in_valid    [NU];
  logic              in_ready    [NU];
  logic [63:0]       in_bits     [NU];
  logic              out_valid   [NU];
  logic              out_ready   [NU];
  logic [6:0]        out_count   [NU];
  logic signed [7:0] out_bipolar [NU];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 64;
    sc_bitstream_counter #(.BITSTREAM(64), .CHUNK(CH)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in_bits     (in_bits[g]),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .out_count   (out_count[g]),
      .out_bipolar (out_bipolar[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int chunk_of(input int u);
    case (u)
      0: return 8;
      1: return 1;
      2: return 4;
      default: return 64;
    endcase
  endfunction

  function automatic int ref_count(input logic [63:0] w);
    return popcount_chunk(w, 0, 64);
  endfunction

  // Stimulus only: present w once in_ready is seen, then wait for out_valid.
  // Called and returns at a negedge; lat counts edges after the accept edge.
  task automatic start_word(input int u, input logic [63:0] w, output int lat);
    int t;
    t = 0;
    while (!in_ready[u] && t < 300) begin
      @(negedge clk);
      t++;
    end
    in_valid[u] = 1'b1;
    in_bits[u]  = w;
    @(posedge clk);
    @(negedge clk);
    in_valid[u] = 1'b0;
    in_bits[u]  = {$urandom, $urandom};
    lat = 0;
    while (!out_valid[u] && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_word(input int u);
    out_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int u = 0; u < NU; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      in_bits[u]   = '1;
    end
    in_valid[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    for (int u = 0; u < NU; u++) begin
      n_cmp += 4;
      if (in_ready[u] !== 1'b1) begin
        n_err++; $display("FAIL reset_in_ready u%0d: got %b want 1", u, in_ready[u]);
      end
      if (out_valid[u] !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid u%0d: got %b want 0", u, out_valid[u]);
      end
      if (out_count[u] !== 7'd0) begin
        n_err++; $display("FAIL reset_count u%0d: got %0d want 0", u, out_count[u]);
      end
      if (int'(out_bipolar[u]) != -64) begin
        n_err++; $display("FAIL reset_bipolar u%0d: got %0d want -64", u, out_bipolar[u]);
      end
    end
  endtask

  task automatic test_basic;
    logic [63:0] words [4];
    int lat, exp_c;
    words[0] = 64'h0;
    words[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    words[2] = 64'hAAAA_AAAA_AAAA_AAAA;
    words[3] = 64'h0000_0000_0000_0001;
    for (int i = 0; i < 4; i++) begin
      start_word(0, words[i], lat);
      exp_c = ref_count(words[i]);
      n_cmp += 3;
      if (lat != 8) begin
        n_err++; $display("FAIL basic_latency w%0d: got %0d want 8", i, lat);
      end
      if (int'(out_count[0]) != exp_c) begin
        n_err++; $display("FAIL basic_count w%0d: got %0d want %0d", i, out_count[0], exp_c);
      end
      if (int'(out_bipolar[0]) != 2 * exp_c - 64) begin
        n_err++; $display("FAIL basic_bipolar w%0d: got %0d want %0d",
                          i, out_bipolar[0], 2 * exp_c - 64);
      end
      finish_word(0);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] w;
    int lat, exp_c;
    w = {$urandom, $urandom};
    exp_c = ref_count(w);
    start_word(0, w, lat);
    // A competing word is offered the whole time the result is pending.
    in_valid[0] = 1'b1;
    in_bits[0]  = ~w;
    for (int c = 0; c < 5; c++) begin
      n_cmp += 4;
      if (out_valid[0] !== 1'b1) begin
        n_err++; $display("FAIL bp_out_valid c%0d: got %b want 1", c, out_valid[0]);
      end
      if (in_ready[0] !== 1'b0) begin
        n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready[0]);
      end
      if (int'(out_count[0]) != exp_c) begin
        n_err++; $display("FAIL bp_count c%0d: got %0d want %0d", c, out_count[0], exp_c);
      end
      if (int'(out_bipolar[0]) != 2 * exp_c - 64) begin
        n_err++; $display("FAIL bp_bipolar c%0d: got %0d want %0d",
                          c, out_bipolar[0], 2 * exp_c - 64);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[0] = 1'b0;
    n_cmp += 2;
    if (out_valid[0] !== 1'b0) begin
      n_err++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid[0]);
    end
    if (in_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready[0]);
    end
    in_valid[0] = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    in_valid[0] = 1'b1;
    in_bits[0]  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst         = 1'b1;
    in_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    n_cmp += 4;
    if (in_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_in_ready: got %b want 1", in_ready[0]);
    end
    if (out_valid[0] !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid[0]);
    end
    if (out_count[0] !== 7'd0) begin
      n_err++; $display("FAIL mid_rst_count: got %0d want 0", out_count[0]);
    end
    if (int'(out_bipolar[0]) != -64) begin
      n_err++; $display("FAIL mid_rst_bipolar: got %0d want -64", out_bipolar[0]);
    end
    start_word(0, 64'h0F0F_0F0F_0F0F_0F0F, lat);
    n_cmp += 2;
    if (lat != 8) begin
      n_err++; $display("FAIL mid_rst_next_latency: got %0d want 8", lat);
    end
    if (out_count[0] !== 7'd32) begin
      n_err++; $display("FAIL mid_rst_next_count: got %0d want 32", out_count[0]);
    end
    finish_word(0);
  endtask

  task automatic test_phase_invariance;
    logic [63:0] w, rot;
    int lat, exp_c;
    w = {$urandom, $urandom};
    exp_c = ref_count(w);
    for (int k = 0; k < 8; k++) begin
      rot = (k == 0) ? w : ((w << k) | (w >> (64 - k)));
      start_word(0, rot, lat);
      n_cmp++;
      if (int'(out_count[0]) != exp_c) begin
        n_err++; $display("FAIL phase_count k%0d: got %0d want %0d", k, out_count[0], exp_c);
      end
      finish_word(0);
    end
  endtask

  task automatic test_sweep;
    logic [63:0] w;
    int lat, exp_c, n, hold, nwords;
    for (int u = 0; u < NU; u++) begin
      n = 64 / chunk_of(u);
      nwords = (u == 0) ? 50 : 200;
      for (int i = 0; i < nwords; i++) begin
        case ($urandom_range(0, 4))
          0: w = {$urandom, $urandom};
          1: w = {$urandom, $urandom} & {$urandom, $urandom};
          2: w = {$urandom, $urandom} | {$urandom, $urandom};
          3: w = ($urandom_range(0, 1) == 1) ? '1 : '0;
          default: w = 64'h1 << $urandom_range(0, 63);
        endcase
        exp_c = ref_count(w);
        start_word(u, w, lat);
        n_cmp += 3;
        if (lat != n) begin
          n_err++; $display("FAIL sweep_latency u%0d i%0d: got %0d want %0d", u, i, lat, n);
        end
        if (int'(out_count[u]) != exp_c) begin
          n_err++; $display("FAIL sweep_count u%0d i%0d: got %0d want %0d",
                            u, i, out_count[u], exp_c);
        end
        if (int'(out_bipolar[u]) != 2 * exp_c - 64) begin
          n_err++; $display("FAIL sweep_bipolar u%0d i%0d: got %0d want %0d",
                            u, i, out_bipolar[u], 2 * exp_c - 64);
        end
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        n_cmp++;
        if (int'(out_count[u]) != exp_c || out_valid[u] !== 1'b1) begin
          n_err++; $display("FAIL sweep_hold u%0d i%0d: got %0d/%b want %0d/1",
                            u, i, out_count[u], out_valid[u], exp_c);
        end
        finish_word(u);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_phase_invariance();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
